// File: rtl/mem_access_initiator.sv
// Load/store requester for a byte-addressed, 16-bit word memory port.
// Unaligned accesses become two aligned accesses; unaligned stores read-modify-write.
module mem_access_initiator #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]           req_wdata,
  output logic                  resp_valid,
  output logic [15:0]           resp_rdata,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    WR_LO = 3'd2,
    RD_HI = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state, state_next;

  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           wdata_q;
  logic [15:0]           buf_q;

  logic                  unaligned;
  logic [ADDR_WIDTH-1:0] lo_addr;
  logic [ADDR_WIDTH-1:0] hi_addr;

  assign unaligned = addr_q[0];
  assign lo_addr   = {addr_q[ADDR_WIDTH-1:1], 1'b0};
  // Adding in ADDR_WIDTH bits makes the top word wrap to address zero.
  assign hi_addr   = lo_addr + ADDR_WIDTH'(2);

  // NOTE: state is non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (req_valid) state_next = (req_wr && !req_addr[0]) ? WR_LO : RD_LO;
      RD_LO: begin
        if (!unaligned)  state_next = DONE;
        else if (wr_q)   state_next = WR_LO;
        else             state_next = RD_HI;
      end
      WR_LO: state_next = unaligned ? RD_HI : DONE;
      RD_HI: state_next = wr_q ? WR_HI : DONE;
      WR_HI: state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory drive is a pure decode of state, so reset drops it without waiting for an edge.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state)
      IDLE:  req_ready = 1'b1;
      RD_LO: begin
        mem_enable = 1'b1;
        mem_addr   = lo_addr;
      end
      WR_LO: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = lo_addr;
        mem_wdata  = unaligned ? {buf_q[15:8], wdata_q[15:8]} : wdata_q;
      end
      RD_HI: begin
        mem_enable = 1'b1;
        mem_addr   = hi_addr;
      end
      WR_HI: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = hi_addr;
        mem_wdata  = {wdata_q[7:0], buf_q[7:0]};
      end
      DONE:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      resp_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          wr_q    <= req_wr;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
        end
        RD_LO: begin
          buf_q <= mem_rdata;
          if (!wr_q && !unaligned) resp_rdata <= mem_rdata;
        end
        RD_HI: begin
          if (wr_q) buf_q      <= mem_rdata;
          else      resp_rdata <= {buf_q[7:0], mem_rdata[15:8]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_access_initiator.md
Name: mem_access_initiator

Overview:
- Requester-side controller that drives the byte-addressable, 16-bit-wide word memory port: enable, wr, addr, data_in, and the combinational data_out.
- Sits between the pipeline's load/store stage and the instruction or main memory.
- Accepts 16-bit load/store requests at any byte address.
- Splits odd-address (unaligned) accesses into aligned word accesses; unaligned stores use read-modify-write.
- Guarantees the memory never sees a read and a write in the same cycle.

Parameters:
- ADDR_WIDTH, 16, width of byte address on both request and memory sides.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_wr  input  1  1 = store, 0 = load
- req_addr  input  ADDR_WIDTH  byte address, any alignment
- req_wdata  input  16  store data; [15:8] goes to byte addr, [7:0] to addr+1
- resp_valid  output  1  one-cycle completion pulse, loads and stores
- resp_rdata  output  16  load result, registered
- mem_enable  output  1  to memory enable
- mem_wr  output  1  to memory wr
- mem_addr  output  ADDR_WIDTH  to memory addr; bit 0 always 0
- mem_wdata  output  16  to memory data_in
- mem_rdata  input  16  from memory data_out, combinational

Behaviour:
- Byte order in memory: word at even address E holds byte E in [15:8] and byte E+1 in [7:0].
- States: IDLE, RD_LO, WR_LO, RD_HI, WR_HI, DONE.
- req_ready = (state == IDLE).
- Accept on the edge where req_valid & req_ready; latch req_wr, req_addr, req_wdata.
- Let lo = {addr[AW-1:1], 0} and hi = lo + 2, computed modulo 2^ADDR_WIDTH (0xFFFF wraps to 0x0000).
- Aligned load: IDLE -> RD_LO -> DONE.
  - RD_LO drives mem_enable=1, mem_wr=0, mem_addr=lo.
  - mem_rdata is captured into resp_rdata at the end of RD_LO.
- Aligned store: IDLE -> WR_LO -> DONE.
  - WR_LO drives enable=1, wr=1, addr=lo, wdata=req_wdata.
- Unaligned load: IDLE -> RD_LO -> RD_HI -> DONE.
  - resp_rdata[15:8] = word(lo)[7:0].
  - resp_rdata[7:0] = word(hi)[15:8].
- Unaligned store: IDLE -> RD_LO -> WR_LO -> RD_HI -> WR_HI -> DONE.
  - WR_LO writes {word(lo)[15:8], wdata[15:8]} to lo.
  - WR_HI writes {wdata[7:0], word(hi)[7:0]} to hi.
  - Read words are held in an internal 16-bit register.
- Latency from the accept edge (cycle N) to resp_valid:
  - aligned load or store: cycle N+2
  - unaligned load: N+3
  - unaligned store: N+5
- DONE: resp_valid=1 for exactly one cycle, then IDLE. No new request is accepted during DONE.
- Stores leave resp_rdata unchanged.
- Every memory cycle is either a read or a write, never both.
- In IDLE and DONE: mem_enable=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- req_valid held during a busy period has no effect; it is accepted on the first IDLE edge.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, all mem_* outputs 0.
- Reset asserted mid-operation:
  - Immediate return to IDLE; mem_enable drops asynchronously.
  - No resp_valid for the aborted request.
  - A partially completed unaligned store may leave the lo word already written; this is permitted.

Test Plan:
- Aligned load 0x0010, mem[0x0010]=0xABCD -> one read cycle at addr 0x0010; resp_valid at N+2; resp_rdata=0xABCD.
- Unaligned load 0x0011, mem[0x0010]=0x1122, mem[0x0012]=0x3344 -> reads 0x0010 then 0x0012; resp_rdata=0x2233 at N+3.
- Unaligned store 0x0011 data 0xAABB, same initial memory -> sequence R0010, W0010=0x11AA, R0012, W0012=0xBB44; resp_valid at N+5; enable&wr never coincides with a read cycle.
- Wrap: unaligned load 0xFFFF, mem[0xFFFE]=0x00EE, mem[0x0000]=0x77FF -> second access at addr 0x0000; resp_rdata=0xEE77.
- Unaligned store 0x0011 with rst low in the RD_HI cycle -> all mem_* and resp_valid 0 immediately; req_ready=1 after release; mem[0x0010]=0x11AA, mem[0x0012]=0x3344.
- req_valid held high for two back-to-back aligned loads -> accepts 3 cycles apart; req_ready low for exactly 2 cycles each; no request dropped or duplicated.
